// File: rtl/spimemio_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spimemio_cfg_pkg
// Description : Shared types and constants for the SPI flash configuration
//               port command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package spimemio_cfg_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        CS_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_e;

    // Bit positions inside the CPU configuration register
    localparam int CFG_CSB_BIT = 5;
    localparam int CFG_CLK_BIT = 4;
    localparam int CFG_DO_LSB  = 0;
    localparam int CFG_EN_BIT  = 31;

    localparam int MAX_PAYLOAD_BYTES = 4;
    localparam int OPCODE_BITS       = 8;
    localparam int SHIFT_W           = OPCODE_BITS * (1 + MAX_PAYLOAD_BYTES);

    // Total bits on the wire: opcode plus clamped payload, i.e. 8*(1+nbytes)
    function automatic logic [5:0] calc_nbits(input logic [2:0] nbytes);
        logic [2:0] nb;
        nb = (nbytes > 3'(MAX_PAYLOAD_BYTES)) ? 3'(MAX_PAYLOAD_BYTES) : nbytes;
        return {nb + 3'd1, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spimemio_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : spimemio_cfg_sequencer_if
// Description : Command/response, CPU config-write and flash pin bundle for
//               the configuration port sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface spimemio_cfg_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic [2:0]  cmd_nbytes;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  cpu_cfg_we;
    logic [31:0] cpu_cfg_di;
    logic        config_en;
    logic        config_csb;
    logic        config_clk;
    logic [3:0]  config_do;
    logic [3:0]  config_di;
    logic        busy;
    logic        lock_err;

    // Requester / flash side
    modport master (
        output cmd_valid, cmd_opcode, cmd_data, cmd_nbytes,
        output cpu_cfg_we, cpu_cfg_di, config_di,
        input  cmd_ready, rsp_valid, rsp_data,
        input  config_en, config_csb, config_clk, config_do, busy, lock_err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_data, cmd_nbytes,
        input  cpu_cfg_we, cpu_cfg_di, config_di,
        output cmd_ready, rsp_valid, rsp_data,
        output config_en, config_csb, config_clk, config_do, busy, lock_err
    );
endinterface
`default_nettype wire

// File: rtl/spimemio_cfg_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : spimemio_cfg_clkgen
// Description : Half-period counter; phase_done_o marks the last clk cycle of
//               each CLK_DIV-cycle sequencer phase.
// Revision    : 1.0 - initial release
// ============================================================================
module spimemio_cfg_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  wire  clk,
    input  wire  resetn,
    input  logic restart_i,
    output logic phase_done_o
);

    localparam logic [7:0] c_last_cnt = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Restart from zero whenever the sequencer changes state
    always_comb begin
        cnt_d = restart_i ? 8'd0 : cnt_q + 8'd1;
    end

    // Counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_done_o = (cnt_q == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/spimemio_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spimemio_cfg_sequencer
// Description : Autonomous single-bit SPI command shifter and arbiter for the
//               flash controller's bit-bang configuration port. CPU register
//               writes are locked out while a command is in flight.
//               Build option: SPIMEMIO_CFG_READBACK_EN enables MISO capture
//               into rsp_data; otherwise rsp_data is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module spimemio_cfg_sequencer
    import spimemio_cfg_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  wire                      clk,
    input  wire                      resetn,
    spimemio_cfg_sequencer_if.slave  bus
);

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shreg_q, shreg_d;
    logic [5:0]           nbits_q, nbits_d;
    logic [5:0]           bitidx_q, bitidx_d;
    logic                 cpu_mode_q, cpu_mode_d;
    logic                 sh_csb_q, sh_csb_d;
    logic                 sh_clk_q, sh_clk_d;
    logic [3:0]           sh_do_q, sh_do_d;

    // Registered outputs
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 lock_err_q, lock_err_d;
    logic                 en_q, en_d;
    logic                 csb_q, csb_d;
    logic                 cclk_q, cclk_d;
    logic [3:0]           do_q, do_d;

    logic w_phase_done;
    logic w_accept;
    logic w_cpu_wr;
    logic w_wr_drop;
    logic w_shift_out;
    logic w_capture;
    logic w_unused_bits;

    spimemio_cfg_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk          (clk),
        .resetn       (resetn),
        .restart_i    (state_d != state_q),
        .phase_done_o (w_phase_done)
    );

    // cmd_ready_q already encodes IDLE && !cpu_mode for the current cycle
    assign w_accept  = bus.cmd_valid && cmd_ready_q;
    assign w_cpu_wr  = |bus.cpu_cfg_we;
    assign w_wr_drop = w_cpu_wr && ((state_q != IDLE) || w_accept);

    // Sequencer next state, shift register and bit counter
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        nbits_d     = nbits_q;
        bitidx_d    = bitidx_q;
        w_shift_out = 1'b0;
        w_capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d  = CS_SETUP;
                    shreg_d  = {bus.cmd_opcode, bus.cmd_data};
                    nbits_d  = calc_nbits(bus.cmd_nbytes);
                    bitidx_d = 6'd0;
                end
            end
            CS_SETUP: begin
                if (w_phase_done) begin
                    state_d     = SHIFT_LO;
                    w_shift_out = 1'b1;
                    shreg_d     = shreg_q << 1;
                end
            end
            SHIFT_LO: begin
                if (w_phase_done) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (w_phase_done) begin
                    // Only bits after the opcode are response bits
                    w_capture = (bitidx_q >= 6'(OPCODE_BITS));
                    if (bitidx_q == nbits_q - 6'd1) begin
                        state_d = CS_HOLD;
                    end else begin
                        state_d     = SHIFT_LO;
                        w_shift_out = 1'b1;
                        shreg_d     = shreg_q << 1;
                        bitidx_d    = bitidx_q + 6'd1;
                    end
                end
            end
            CS_HOLD: begin
                if (w_phase_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CPU register writes, applied only when a strobe is set and not locked out
    always_comb begin
        cpu_mode_d = cpu_mode_q;
        sh_csb_d   = sh_csb_q;
        sh_clk_d   = sh_clk_q;
        sh_do_d    = sh_do_q;
        if (w_cpu_wr && !w_wr_drop) begin
            if (bus.cpu_cfg_we[3]) begin
                cpu_mode_d = bus.cpu_cfg_di[CFG_EN_BIT];
            end
            if (bus.cpu_cfg_we[0]) begin
                sh_csb_d = bus.cpu_cfg_di[CFG_CSB_BIT];
                sh_clk_d = bus.cpu_cfg_di[CFG_CLK_BIT];
                sh_do_d  = bus.cpu_cfg_di[CFG_DO_LSB +: 4];
            end
        end
    end

    // Output values for the coming cycle, derived from next state
    always_comb begin
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE) && !cpu_mode_d;
        rsp_valid_d = (state_d == DONE);
        lock_err_d  = w_wr_drop;
        en_d        = 1'b0;
        csb_d       = 1'b1;
        cclk_d      = 1'b0;
        do_d        = 4'b0000;
        if (state_d != IDLE) begin
            en_d   = 1'b1;
            csb_d  = (state_d == DONE);
            cclk_d = (state_d == SHIFT_HI);
            // MOSI only moves when a new SHIFT_LO phase begins
            do_d   = {3'b000, w_shift_out ? shreg_q[SHIFT_W-1] : do_q[0]};
        end else if (cpu_mode_d) begin
            en_d   = 1'b1;
            csb_d  = sh_csb_d;
            cclk_d = sh_clk_d;
            do_d   = sh_do_d;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            nbits_q     <= 6'd0;
            bitidx_q    <= 6'd0;
            cpu_mode_q  <= 1'b0;
            sh_csb_q    <= 1'b1;
            sh_clk_q    <= 1'b0;
            sh_do_q     <= 4'b0000;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            lock_err_q  <= 1'b0;
            en_q        <= 1'b0;
            csb_q       <= 1'b1;
            cclk_q      <= 1'b0;
            do_q        <= 4'b0000;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            nbits_q     <= nbits_d;
            bitidx_q    <= bitidx_d;
            cpu_mode_q  <= cpu_mode_d;
            sh_csb_q    <= sh_csb_d;
            sh_clk_q    <= sh_clk_d;
            sh_do_q     <= sh_do_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            lock_err_q  <= lock_err_d;
            en_q        <= en_d;
            csb_q       <= csb_d;
            cclk_q      <= cclk_d;
            do_q        <= do_d;
        end
    end

`ifdef SPIMEMIO_CFG_READBACK_EN
    logic [31:0] cap_q, cap_d;

    // MISO capture: cleared per command, shifted in from the LSB
    always_comb begin
        cap_d = cap_q;
        if (w_accept) begin
            cap_d = 32'd0;
        end else if (w_capture) begin
            cap_d = {cap_q[30:0], bus.config_di[1]};
        end
    end

    // Capture register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_q <= 32'd0;
        end else begin
            cap_q <= cap_d;
        end
    end

    assign bus.rsp_data = cap_q;
    assign w_unused_bits = ^{bus.cpu_cfg_we[2:1], bus.cpu_cfg_di[30:6],
                             bus.config_di[3:2], bus.config_di[0]};
`else
    assign bus.rsp_data = 32'd0;
    assign w_unused_bits = ^{bus.cpu_cfg_we[2:1], bus.cpu_cfg_di[30:6],
                             bus.config_di, w_capture};
`endif

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.busy       = busy_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.lock_err   = lock_err_q;
    assign bus.config_en  = en_q;
    assign bus.config_csb = csb_q;
    assign bus.config_clk = cclk_q;
    assign bus.config_do  = do_q;

endmodule
`default_nettype wire

// File: tb/tb_spimemio_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spimemio_cfg_sequencer
// Description : Self-checking bench for spimemio_cfg_sequencer with a small
//               flash model and a response scoreboard. Honours
//               SPIMEMIO_CFG_READBACK_EN for the expected rsp_data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spimemio_cfg_sequencer;

    localparam int CLK_DIV = 2;
`ifdef SPIMEMIO_CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    spimemio_cfg_sequencer_if bus ();

    spimemio_cfg_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t        sb_q[$];
    exp_t        m_e;
    int          rsp_seen = 0;
    int          pulses = 0;
    logic [39:0] mosi_bits = '0;
    int          do_hi_err = 0;
    int          lock_cnt = 0;
    int          cur_nbits = 8;
    logic [31:0] miso_payload = '0;
    logic        prev_csb = 1'b1;
    logic        prev_cclk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Flash model, pin monitor and response scoreboard
    always @(negedge clk) begin
        if (bus.config_csb) bus.config_di = 4'b0000;
        if (prev_csb && !bus.config_csb) begin
            pulses    = 0;
            mosi_bits = '0;
        end
        if (bus.config_clk && !prev_cclk) begin
            mosi_bits = {mosi_bits[38:0], bus.config_do[0]};
            if (pulses >= 8 && pulses < cur_nbits)
                bus.config_di = {2'b00, miso_payload[cur_nbits-1-pulses], 1'b0};
            else
                bus.config_di = 4'b0000;
            pulses++;
        end
        if (bus.busy && bus.config_do[3:1] != 3'b000) do_hi_err++;
        if (bus.lock_err === 1'b1) lock_cnt++;
        prev_csb  = bus.config_csb;
        prev_cclk = bus.config_clk;
        if (resetn && bus.rsp_valid === 1'b1) begin
            rsp_seen++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid at cycle %0d data %h, none expected", cyc, bus.rsp_data);
            end else begin
                m_e = sb_q.pop_front();
                if (bus.rsp_data !== m_e.data || cyc != m_e.cycle) begin
                    errors++;
                    $display("FAIL rsp: got data %h at cycle %0d, expected %h at cycle %0d",
                             bus.rsp_data, cyc, m_e.data, m_e.cycle);
                end
            end
        end
    end

    // Present a command, wait (bounded) for acceptance, push the expectation
    task automatic issue(input logic [7:0] op, input logic [31:0] data,
                         input logic [2:0] nb, input logic [31:0] payload);
        int n;
        int w;
        logic [31:0] exp_d;
        n = 8 * (1 + ((nb > 3'd4) ? 4 : int'(nb)));
        exp_d = 32'd0;
        for (int i = 0; i < n - 8; i++) exp_d[i] = payload[i];
        if (!READBACK) exp_d = 32'd0;
        cur_nbits      = n;
        miso_payload   = payload;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_data   = data;
        bus.cmd_nbytes = nb;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: cmd_ready %b, expected 1", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        sb_q.push_back('{exp_d, cyc + 1 + CLK_DIV * (2 + 2 * n)});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int w;
        w = 0;
        while ((sb_q.size() != 0 || bus.busy !== 1'b0) && w < limit) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= limit) begin
            errors++;
            $display("FAIL wait_done: pending %0d busy %b, expected 0 and 0", sb_q.size(), bus.busy);
            sb_q.delete();
        end
    endtask

    task automatic check_pins(input string name, input logic [6:0] exp_pins, input logic exp_ready);
        checks++;
        if ({bus.config_en, bus.config_csb, bus.config_clk, bus.config_do} !== exp_pins ||
            bus.cmd_ready !== exp_ready) begin
            errors++;
            $display("FAIL %s: en/csb/clk/do %b ready %b, expected %b ready %b", name,
                     {bus.config_en, bus.config_csb, bus.config_clk, bus.config_do},
                     bus.cmd_ready, exp_pins, exp_ready);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = 8'h00; bus.cmd_data = 32'd0; bus.cmd_nbytes = 3'd0;
        bus.cpu_cfg_we = 4'b0000; bus.cpu_cfg_di = 32'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({bus.config_en, bus.config_csb, bus.config_clk, bus.config_do, bus.rsp_valid,
                 bus.rsp_data, bus.busy, bus.lock_err, bus.cmd_ready} !== {7'b0100000, 1'b0, 32'd0, 3'b001}) begin
                errors++;
                $display("FAIL reset_state[%0d]: en %b csb %b clk %b do %h rv %b rd %h busy %b le %b rdy %b, expected 0 1 0 0 0 0 0 0 1",
                         k, bus.config_en, bus.config_csb, bus.config_clk, bus.config_do, bus.rsp_valid,
                         bus.rsp_data, bus.busy, bus.lock_err, bus.cmd_ready);
            end
            resetn = 1'b1;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic check_shift(input string name, input int exp_pulses, input logic [39:0] exp_bits);
        checks++;
        if (pulses != exp_pulses || mosi_bits !== exp_bits || do_hi_err != 0) begin
            errors++;
            $display("FAIL %s: pulses %0d mosi %h do_hi %0d, expected %0d %h 0",
                     name, pulses, mosi_bits, do_hi_err, exp_pulses, exp_bits);
        end
    endtask

    task automatic test_write_enable();
        issue(8'h06, 32'h0, 3'd0, 32'h0);
        wait_done(200);
        check_shift("wren_shift", 8, 40'h06);
    endtask

    task automatic test_jedec_read();
        issue(8'h9F, 32'h12345678, 3'd3, 32'h00EF4018);
        wait_done(300);
        check_shift("jedec_shift", 32, {8'h00, 8'h9F, 24'h123456});
    endtask

    task automatic test_nbytes_clamp();
        issue(8'h01, 32'hDEADBEEF, 3'd7, 32'hCAFEF00D);
        wait_done(400);
        check_shift("clamp_shift", 40, {8'h01, 32'hDEADBEEF});
    endtask

    task automatic test_back_to_back();
        issue(8'h05, 32'h0, 3'd0, 32'h0);
        issue(8'h35, 32'h0, 3'd0, 32'h0);
        issue(8'h50, 32'h0, 3'd0, 32'h0);
        wait_done(300);
    endtask

    task automatic test_cpu_mode();
        bus.cpu_cfg_we = 4'b1000; bus.cpu_cfg_di = 32'h8000_0000;
        @(negedge clk);
        bus.cpu_cfg_we = 4'b0001; bus.cpu_cfg_di = 32'h0000_001A;
        check_pins("cpu_mode_on", 7'b1100000, 1'b0);
        @(negedge clk);
        bus.cpu_cfg_we = 4'b0000;
        check_pins("cpu_shadow", 7'b1011010, 1'b0);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 8'h06; bus.cmd_nbytes = 3'd0;
        repeat (5) @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.lock_err !== 1'b0) begin
            errors++;
            $display("FAIL cpu_blocks_cmd: busy %b lock_err %b, expected 0 0", bus.busy, bus.lock_err);
        end
    endtask

    task automatic test_no_strobe();
        for (int i = 0; i < 10; i++) begin
            bus.cpu_cfg_we = 4'b0000;
            bus.cpu_cfg_di = (i % 2 == 0) ? 32'h0000_0000 : 32'hFFFF_FFDF;
            @(negedge clk);
            check_pins("no_strobe", 7'b1011010, 1'b0);
        end
        bus.cpu_cfg_we = 4'b1000; bus.cpu_cfg_di = 32'h0000_0000;
        @(negedge clk);
        bus.cpu_cfg_we = 4'b0000;
        check_pins("cpu_mode_off", 7'b0100000, 1'b1);
    endtask

    task automatic test_busy_write();
        int l0;
        issue(8'h06, 32'h0, 3'd0, 32'h0);
        l0 = lock_cnt;
        for (int i = 0; i < 10; i++) begin
            bus.cpu_cfg_we = (i == 4) ? 4'b1001 : 4'b0001;
            bus.cpu_cfg_di = (i % 2 == 0) ? 32'h8000_0025 : 32'h8000_0000;
            @(negedge clk);
        end
        bus.cpu_cfg_we = 4'b0000;
        wait_done(200);
        checks++;
        if (lock_cnt - l0 != 10 || bus.config_en !== 1'b0) begin
            errors++;
            $display("FAIL busy_write_lock: lock cycles %0d en %b, expected 10 0", lock_cnt - l0, bus.config_en);
        end
        bus.cpu_cfg_we = 4'b1000; bus.cpu_cfg_di = 32'h8000_0000;
        @(negedge clk);
        bus.cpu_cfg_we = 4'b1000; bus.cpu_cfg_di = 32'h0000_0000;
        check_pins("busy_write_shadow", 7'b1011010, 1'b0);
        @(negedge clk);
        bus.cpu_cfg_we = 4'b0000;
    endtask

    task automatic test_simultaneous();
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        cur_nbits = 8;
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 8'h06; bus.cmd_nbytes = 3'd0; bus.cmd_data = 32'd0;
        bus.cpu_cfg_we = 4'b1000; bus.cpu_cfg_di = 32'h8000_0000;
        sb_q.push_back('{32'd0, cyc + 1 + CLK_DIV * 18});
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cpu_cfg_we = 4'b0000;
        checks++;
        if (bus.lock_err !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_lock: lock_err %b busy %b, expected 1 1", bus.lock_err, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.lock_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_pulse: lock_err %b, expected 0", bus.lock_err);
        end
        wait_done(200);
        check_pins("simul_cpu_mode", 7'b0100000, 1'b1);
    endtask

    task automatic test_reset_mid();
        int w;
        int rs0;
        issue(8'h9F, 32'h0, 3'd3, 32'h00ABCDEF);
        w = 0;
        while (bus.config_clk !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (bus.config_csb !== 1'b1 || bus.busy !== 1'b0 || w >= 50) begin
            errors++;
            $display("FAIL reset_mid_csb: csb %b busy %b wait %0d, expected 1 0 <50", bus.config_csb, bus.busy, w);
        end
        sb_q.delete();
        rs0 = rsp_seen;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (rsp_seen != rs0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: rsp count %0d ready %b busy %b, expected %0d 1 0",
                     rsp_seen, bus.cmd_ready, bus.busy, rs0);
        end
    endtask

    initial begin
        test_reset();
        test_write_enable();
        test_jedec_read();
        test_nbytes_clamp();
        test_back_to_back();
        test_cpu_mode();
        test_no_strobe();
        test_busy_write();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spimemio_cfg_sequencer.md
# spimemio_cfg_sequencer

Hardware command sequencer and access arbiter for the SPI flash controller's bit-bang configuration port (config_en / config_csb / config_clk / config_do). It shifts complete single-bit SPI flash commands autonomously, such as write-enable, status-register write or JEDEC-ID read. It also arbitrates that port against direct CPU configuration-register writes. CPU writes are qualified by the write strobe alone and are locked out while a command is in flight.

## Interface
- CLK_DIV, 2: clk cycles per SPI half-period; legal range 1..255.
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_opcode  in  8  SPI opcode, sent first
- cmd_data  in  32  payload bytes, sent starting at [31:24]
- cmd_nbytes  in  3  payload byte count, 0..4; values 5..7 are treated as 4
- rsp_valid  out  1  one-cycle pulse at command completion
- rsp_data  out  32  MISO bits captured during the payload phase, right-aligned
- cpu_cfg_we  in  4  CPU config-register byte write strobes
- cpu_cfg_di  in  32  CPU config-register write data
- config_en  out  1  bit-bang mode enable to the flash pins
- config_csb  out  1  chip select, active low
- config_clk  out  1  SPI clock
- config_do  out  4  IO output; only bit 0 (MOSI) is used by the sequencer
- config_di  in  4  IO input; bit 1 is MISO
- busy  out  1  high whenever the state is not IDLE
- lock_err  out  1  one-cycle pulse when a CPU write is rejected

## Operation
- States: IDLE, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD, DONE.
- Each state except IDLE and DONE lasts exactly CLK_DIV cycles. DONE lasts 1 cycle.
- cmd_ready = (state == IDLE) && !cpu_mode.
- On acceptance, latch opcode, data and nbits. nbits = 8*(1+nbytes), with nbytes clamped to 4.
- Transitions:
  - IDLE → CS_SETUP on command acceptance.
  - CS_SETUP → SHIFT_LO.
  - SHIFT_LO → SHIFT_HI.
  - SHIFT_HI → SHIFT_LO while bits remain.
  - SHIFT_HI → CS_HOLD after the last bit.
  - CS_HOLD → DONE.
  - DONE → IDLE.
- Output values by state while the sequencer is active:
  - config_en = 1.
  - config_csb = 0 in CS_SETUP through CS_HOLD, 1 in DONE.
  - config_clk = 1 only in SHIFT_HI.
- config_do[0] presents the current bit in MSB-first order. It changes only on SHIFT_LO entry. config_do[3:1] = 0.
- MISO (config_di[1]) is sampled on the last cycle of SHIFT_HI, for payload bits only. Captured bits are shifted into rsp_data from the LSB.
- CPU path:
  - A cpu_cfg_we[3] write sets cpu_mode = cpu_cfg_di[31].
  - A cpu_cfg_we[0] write loads the shadow register from cpu_cfg_di: csb ← [5], clk ← [4], do ← [3:0].
  - Writes take effect only when a write strobe is set. config_en is never an alternative qualifier.
- Output values in IDLE:
  - cpu_mode = 1: config_en = 1, and the pins follow the shadow register.
  - cpu_mode = 0: config_en = 0, csb = 1, clk = 0, do = 0.
- Any CPU write while busy is dropped, and lock_err pulses for one cycle.
- If a CPU write and command acceptance occur in the same cycle, the command wins. The write is dropped and lock_err pulses.

## Timing
- Reset values:
  - state = IDLE, cpu_mode = 0.
  - Shadow register: csb = 1, clk = 0, do = 0.
  - Outputs: config_en = 0, config_csb = 1, config_clk = 0, config_do = 0, rsp_valid = 0, rsp_data = 0, busy = 0, lock_err = 0, cmd_ready = 1.
- Reset during a command:
  - config_csb goes to 1 asynchronously.
  - The in-flight command is abandoned and no rsp_valid is issued.
- Command accepted in cycle T:
  - busy and config_en are high from T+1.
  - rsp_valid is high in cycle T+1+CLK_DIV*(2+2*nbits).
  - cmd_ready is high again in the cycle after rsp_valid.
- All outputs are registered.
- The bit counter is 6 bits wide (maximum nbits = 40).
- The half-period counter is 8 bits wide and reloads on every state change.

## Configuration
- SPIMEMIO_CFG_READBACK_EN defined: MISO capture is active and rsp_data is driven as described above.
- Not defined: rsp_data is tied to 0 and config_di is unused. All timing is identical.

## Structure
- Package spimemio_cfg_pkg holds:
  - The state enum.
  - Field positions: CFG_CSB_BIT = 5, CFG_CLK_BIT = 4, CFG_DO_LSB = 0, CFG_EN_BIT = 31.
  - MAX_PAYLOAD_BYTES = 4.
- Sub-module spimemio_cfg_clkgen holds the half-period counter and produces a phase_done pulse.
- The FSM, shift registers and CPU arbitration live in the top-level module.

## Test plan
- CLK_DIV = 2, opcode 0x06, nbytes = 0, accepted at T → 8 config_clk pulses, MOSI pattern 00000110, rsp_valid at T+37.
- Opcode 0x9F, nbytes = 3, MISO driven with 0xEF4018 → rsp_data = 0x00EF4018; with the macro undefined → rsp_data = 0.
- CPU write we = 4'b1000 with di[31] = 1, then we = 4'b0001 with di = 0x0000001A → config_en = 1, csb = 0, clk = 1, do = 0xA; cmd_ready = 0 while cpu_mode = 1.
- cpu_cfg_we = 0 with di[5] = 0, toggled over 10 cycles → no pin change. Same stimulus with we[0] = 1 while busy → no pin change and lock_err pulses.
- cmd_valid and a cpu_cfg_we[3] write in the same idle cycle → command runs, cpu_mode stays 0, lock_err = 1 for one cycle.
- resetn deasserted mid-SHIFT_HI → config_csb = 1 immediately, no rsp_valid, cmd_ready = 1 after reset release.
